// File: rtl/serial_compare_accum.sv
// Word-level magnitude compare built from a stream of per-bit comparator results, MSB first.
// The first decisive bit fixes the word result. Non-one-hot bit codes raise a sticky err flag.
module serial_compare_accum #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic greater,
    input  logic lesser,
    input  logic equal,
    output logic busy,
    output logic done,
    output logic a_gt,
    output logic a_lt,
    output logic a_eq,
    output logic err
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          dec_q, gt_q, lt_q;
    logic          busy_q, done_q, a_gt_q, a_lt_q, a_eq_q, err_q;

    logic onehot, decisive, dec_d, gt_d, lt_d;

    // An illegal code never decides the word, even if greater or lesser is set in it.
    always_comb begin
        onehot   = $onehot({greater, lesser, equal});
        decisive = onehot & ~equal & ~dec_q;
        dec_d    = dec_q | decisive;
        gt_d     = decisive ? greater : gt_q;
        lt_d     = decisive ? lesser  : lt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_gt_q  <= 1'b0;
            a_lt_q  <= 1'b0;
            a_eq_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        dec_q   <= 1'b0;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        a_gt_q  <= 1'b0;
                        a_lt_q  <= 1'b0;
                        a_eq_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (start) begin
                        cnt_q  <= '0;
                        dec_q  <= 1'b0;
                        gt_q   <= 1'b0;
                        lt_q   <= 1'b0;
                        err_q  <= 1'b0;
                    end else if (bit_valid) begin
                        cnt_q <= cnt_q + CW'(1);
                        dec_q <= dec_d;
                        gt_q  <= gt_d;
                        lt_q  <= lt_d;
                        if (!onehot)
                            err_q <= 1'b1;
                        if (cnt_q == LAST) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            a_gt_q  <= gt_d;
                            a_lt_q  <= lt_d;
                            a_eq_q  <= ~gt_d & ~lt_d;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        dec_q   <= 1'b0;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        a_gt_q  <= 1'b0;
                        a_lt_q  <= 1'b0;
                        a_eq_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign a_gt = a_gt_q;
    assign a_lt = a_lt_q;
    assign a_eq = a_eq_q;
    assign err  = err_q;
endmodule

// File: tb/tb_serial_compare_accum.sv
// Directed and randomized checks of serial_compare_accum at WIDTH=4 against a word-level model.
module tb_serial_compare_accum;
    localparam int W = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, bit_valid = 1'b0, greater = 1'b0, lesser = 1'b0, equal = 1'b0;
    logic busy, done, a_gt, a_lt, a_eq, err;

    int n_chk = 0, n_fail = 0;

    serial_compare_accum #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
        .greater(greater), .lesser(lesser), .equal(equal),
        .busy(busy), .done(done), .a_gt(a_gt), .a_lt(a_lt), .a_eq(a_eq), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: result is the first legal gt/lt code in MSB-first order; err if any code is not one-hot.
    function automatic logic [3:0] model(input logic [3*W-1:0] codes);
        logic [2:0] c;
        logic gt, lt, e, found;
        gt = 0; lt = 0; e = 0; found = 0;
        for (int i = W - 1; i >= 0; i--) begin
            c = codes[3*i +: 3];
            if ($countones(c) != 1) e = 1;
            else if (!found && c != 3'b001) begin
                found = 1;
                gt = (c == 3'b100);
                lt = (c == 3'b010);
            end
        end
        return {gt, lt, !found, e};
    endfunction

    task automatic chk_outs(input string tag, input logic [3:0] exp);
        chk({tag, ".gt"}, a_gt, exp[3]);
        chk({tag, ".lt"}, a_lt, exp[2]);
        chk({tag, ".eq"}, a_eq, exp[1]);
        chk({tag, ".err"}, err, exp[0]);
    endtask

    task automatic drive_bit(input logic [2:0] c);
        bit_valid = 1'b1;
        {greater, lesser, equal} = c;
    endtask

    task automatic idle_inputs();
        bit_valid = 1'b0;
        {greater, lesser, equal} = 3'b000;
    endtask

    // One full word: start (optionally with a bit that must be ignored), W bits with gaps, done, hold.
    task automatic run_word(input string tag, input logic [3*W-1:0] codes, input int gap,
                            input bit valid_on_start);
        logic [3:0] exp;
        exp = model(codes);
        start = 1'b1;
        if (valid_on_start) drive_bit(3'b100);
        tick();
        start = 1'b0;
        idle_inputs();
        chk({tag, ".busy_start"}, busy, 1'b1);
        chk({tag, ".run_outs"}, {a_gt, a_lt, a_eq, err}, 4'b0000);
        for (int i = W - 1; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) begin
                idle_inputs();
                tick();
                chk({tag, ".gap_busy"}, {busy, done}, 2'b10);
            end
            drive_bit(codes[3*i +: 3]);
            tick();
            if (i > 0) chk({tag, ".mid_busy"}, {busy, done}, 2'b10);
        end
        idle_inputs();
        chk({tag, ".done"}, {busy, done}, 2'b01);
        chk_outs({tag, ".res"}, exp);
        tick();
        chk({tag, ".idle"}, {busy, done}, 2'b00);
        chk_outs({tag, ".hold"}, exp);
    endtask

    initial begin
        logic [3*W-1:0] codes;
        logic [3:0] exp;
        #2;
        chk("reset", {busy, done, a_gt, a_lt, a_eq, err}, 6'b0);
        @(negedge clk);
        rst = 1'b0;

        // First edge after reset release must accept start.
        run_word("gt", {3'b001, 3'b001, 3'b100, 3'b010}, 0, 0);
        run_word("eq", {4{3'b001}}, 0, 0);
        run_word("eq_gap", {4{3'b001}}, 2, 0);
        run_word("err", {3'b001, 3'b110, 3'b001, 3'b001}, 0, 0);
        run_word("lt_sv", {3'b010, 3'b100, 3'b100, 3'b100}, 1, 1);
        run_word("illegal_gt", {3'b101, 3'b001, 3'b010, 3'b000}, 0, 0);

        // bit_valid in IDLE is ignored; previous result held.
        drive_bit(3'b100);
        repeat (3) tick();
        idle_inputs();
        chk("idle_ignore", {busy, done}, 2'b00);
        chk_outs("idle_hold", model({3'b101, 3'b001, 3'b010, 3'b000}));

        // Abort after two bits: no done, second word's result stands.
        start = 1'b1; tick(); start = 1'b0;
        drive_bit(3'b100); tick();
        drive_bit(3'b100); tick();
        idle_inputs();
        chk("abort_busy", {busy, done}, 2'b10);
        run_word("abort2", {3'b010, 3'b100, 3'b100, 3'b100}, 0, 0);

        // start while in DONE: pulse still occurs, then straight into RUN.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < W; i++) begin drive_bit(3'b100); tick(); end
        idle_inputs();
        chk("dstart_done", {busy, done, a_gt}, 3'b011);
        start = 1'b1; tick(); start = 1'b0;
        chk("dstart_run", {busy, done, a_gt, a_lt, a_eq}, 5'b10000);
        for (int i = 0; i < W; i++) begin drive_bit(3'b001); tick(); end
        idle_inputs();
        chk("dstart_res", {busy, done, a_gt, a_lt, a_eq}, 5'b01001);
        tick();

        // Asynchronous reset mid-word.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin drive_bit(3'b011); tick(); end
        idle_inputs();
        chk("pre_rst_err", err, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {busy, done, a_gt, a_lt, a_eq, err}, 6'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_no_done", {busy, done}, 2'b00);
        run_word("post_rst", {3'b001, 3'b010, 3'b001, 3'b100}, 0, 0);

        // Randomized words, biased toward equal bits so decisions land at varied positions.
        for (int w = 0; w < 40; w++) begin
            for (int i = 0; i < W; i++) begin
                int r;
                r = $urandom_range(0, 9);
                codes[3*i +: 3] = (r < 5) ? 3'b001 : (r < 7) ? 3'b100 : (r < 9) ? 3'b010
                                  : 3'($urandom_range(0, 7));
            end
            exp = model(codes);
            run_word($sformatf("rnd%0d", w), codes, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_compare_accum.md
SERIAL_COMPARE_ACCUM -- requirements
Module: serial_compare_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bit results per word (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  begins a new word comparison.
REQ-005 SHALL have port bit_valid  input  1  marks greater/lesser/equal as valid this cycle.
REQ-006 SHALL have port greater  input  1  one-bit comparator result a>b for the current bit.
REQ-007 SHALL have port lesser  input  1  one-bit comparator result a<b for the current bit.
REQ-008 SHALL have port equal  input  1  one-bit comparator result a==b for the current bit.
REQ-009 SHALL have port busy  output  1  high while a word is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse; the word result is final.
REQ-011 SHALL have port a_gt  output  1  word result a>b.
REQ-012 SHALL have port a_lt  output  1  word result a<b.
REQ-013 SHALL have port a_eq  output  1  word result a==b.
REQ-014 SHALL have port err  output  1  sticky flag: an illegal input code was seen during the word.

Function
REQ-015 SHALL accept bit results MSB first, one per clk edge where bit_valid=1 in state RUN.
REQ-016 SHALL implement three states: IDLE, RUN and DONE.
REQ-017 Transition IDLE->RUN SHALL occur on start=1, which also clears the bit counter, the decided flag, the result registers and err.
REQ-018 Transition RUN->DONE SHALL occur on the edge that samples the WIDTH-th valid bit; DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-019 done SHALL be 1 only in DONE, for exactly one cycle; busy SHALL be 1 only in RUN.
REQ-020 The first accepted bit with greater=1 or lesser=1 SHALL latch the word decision; all later bits of that word SHALL NOT change it.
REQ-021 If no decisive bit arrives among the WIDTH valid bits, the result SHALL be a_eq=1.
REQ-022 In DONE and in the following IDLE, exactly one of a_gt/a_lt/a_eq SHALL be 1, held until the next start.
REQ-023 While in RUN, a_gt/a_lt/a_eq SHALL all read 0.
REQ-024 An accepted bit whose {greater,lesser,equal} is not one-hot SHALL set err, SHALL count toward WIDTH, and SHALL be treated as non-decisive.
REQ-025 The bit counter SHALL be clog2(WIDTH+1) bits wide and SHALL NOT wrap within a word.
REQ-026 bit_valid in IDLE or DONE SHALL be ignored.
REQ-027 Gaps (bit_valid=0) in RUN SHALL stall the counter with no timeout.
REQ-028 start in RUN SHALL abort the current word and restart it (same as REQ-017), with no done pulse.
REQ-029 start in DONE SHALL take effect: the done pulse still occurs that cycle and the next state SHALL be RUN.
REQ-030 start and bit_valid in the same cycle SHALL apply start only; that bit SHALL NOT be accepted.

Reset
REQ-031 rst=1 SHALL force, asynchronously: state IDLE, counter 0, busy=0, done=0, a_gt=0, a_lt=0, a_eq=0, err=0.
REQ-032 Reset mid-word SHALL discard all progress; no done pulse SHALL follow the release of rst.
REQ-033 After rst deasserts, the block SHALL accept start on the first clk edge.

Verification (WIDTH=4)
REQ-034 Sequence start, then bits eq,eq,gt,lt (a=1010, b=1001) SHALL give done one cycle after the 4th bit with a_gt=1, a_lt=0, a_eq=0, err=0.
REQ-035 Sequence start, then 4 bits of eq SHALL give a_eq=1; the same with 2-cycle bit_valid gaps SHALL give an identical result, with done delayed by the gap count.
REQ-036 Sequence start, then 2 bits, then start, then lt,gt,gt,gt SHALL give no done after the first start and a_lt=1 after the second word.
REQ-037 A word with bit 2 = {1,1,0} and all other bits eq SHALL give err=1 and a_eq=1.
REQ-038 rst pulse after 3 bits SHALL force all outputs to 0 immediately; a following full word SHALL complete normally.
